ram_write_arbiter: RTL

Parametrised N-channel write arbiter feeding the shared feature/image RAM. Replaces the static combinational input select with handshaked, burst-locked arbitration across producers (file loader, decompressor, CNN layer output, layer input, ...). Output is registered, so the RAM sees one write per accepted word with an auto-incrementing address. Sits between the producer channels and the RAM write port.

---
 rtl/ram_arb_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/ram_write_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared types and helpers for the RAM write arbiter.
//               Arbiter state encoding, arbitration mode constants and a
//               one-hot to index helper. Sized for up to c_maxCh channels.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    localparam int c_maxCh     = 8;
    localparam int c_modeFixed = 0;
    localparam int c_modeRr    = 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arbState_t;

    // Index of the set bit of a one-hot vector; 0 when the vector is zero.
    function automatic logic [2:0] oneHotToIdx(input logic [c_maxCh-1:0] oneHot);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < c_maxCh; i++) begin
            if (oneHot[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational request-to-grant arbiter.
//               RR_MODE = 0 : fixed priority, lowest index wins.
//               RR_MODE = 1 : first request at or after i_ptr, wrapping.
// Ports       : i_req  - per-channel request vector
//               i_ptr  - round-robin start index (ignored in fixed mode)
//               o_gnt  - one-hot grant, zero when no request
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int RR_MODE = 0,
    parameter int PTR_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [PTR_W-1:0]  i_ptr,
    output logic [NUM_CH-1:0] o_gnt
);

    int               w_start;
    logic [PTR_W-1:0] w_idx;
    logic             w_found;

    // Fixed priority is simply a rotation that always starts at channel 0.
    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        w_start = (RR_MODE == c_modeRr) ? int'(i_ptr) : 0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_idx = PTR_W'((w_start + k) % NUM_CH);
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_write_arbiter
// Description : N-channel burst-locked write arbiter in front of the shared
//               feature/image RAM. One cycle of arbitration in IDLE, then the
//               winner owns the RAM port until it delivers a word with
//               ch_last. Registered write port with auto-incrementing address.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               ch_valid/ch_last/ch_data - producer channels (packed words)
//               ch_ready                 - per-channel accept
//               addr_load/base_addr      - base address load (IDLE only)
//               ram_stall                - RAM back-pressure
//               ram_we/ram_addr/ram_data - registered RAM write port
//               grant/busy/done          - status
//               addr_wrap                - sticky address wrap flag
//               word_count               - words in current/last burst
//                                          (only with WORD_COUNT_EN)
// Options     : `define WORD_COUNT_EN to add the word_count output.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_write_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 13,
    parameter int RR_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH-1:0]        ch_last,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_ready,
    input  logic                     addr_load,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic                     ram_stall,
    output logic                     ram_we,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [DATA_W-1:0]        ram_data,
    output logic [NUM_CH-1:0]        grant,
    output logic                     busy,
    output logic                     done,
    output logic                     addr_wrap
`ifdef WORD_COUNT_EN
    ,
    output logic [ADDR_W-1:0]        word_count
`endif
);
    import ram_arb_pkg::*;

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    arbState_t         r_state;
    arbState_t         w_stateNxt;
    logic [NUM_CH-1:0] r_grant;
    logic [NUM_CH-1:0] w_arbGrant;
    logic [NUM_CH-1:0] w_ready;
    logic [PTR_W-1:0]  r_rrPtr;
    logic [PTR_W-1:0]  w_grantIdx;
    logic [c_maxCh-1:0] w_grantPad;
    logic [DATA_W-1:0] w_chWord [NUM_CH];
    logic [DATA_W-1:0] w_selData;
    logic              w_anyValid;
    logic              w_xfer;
    logic              w_xferLast;
    logic              w_busy;
    logic [ADDR_W-1:0] r_addrCnt;
    logic [ADDR_W-1:0] r_ramAddr;
    logic [DATA_W-1:0] r_ramData;
    logic              r_ramWe;
    logic              r_done;
    logic              r_addrWrap;

    // ------------------------------------------------------------------
    // Channel word unpack and owner selection
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign w_chWord[i] = ch_data[i*DATA_W +: DATA_W];
    end

    always_comb begin
        w_grantPad             = '0;
        w_grantPad[NUM_CH-1:0] = r_grant;
    end

    assign w_grantIdx = PTR_W'(oneHotToIdx(w_grantPad));
    assign w_selData  = w_chWord[w_grantIdx];
    assign w_anyValid = |ch_valid;
    assign w_xfer     = |(ch_valid & w_ready);
    assign w_xferLast = w_xfer & ch_last[w_grantIdx];

    rr_arbiter #(
        .NUM_CH  (NUM_CH),
        .RR_MODE (RR_MODE),
        .PTR_W   (PTR_W)
    ) u_arb (
        .i_req (ch_valid),
        .i_ptr (r_rrPtr),
        .o_gnt (w_arbGrant)
    );

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNxt;
        end
    end

    always_comb begin
        w_stateNxt = r_state;
        case (r_state)
            IDLE:    if (w_anyValid) w_stateNxt = BURST;
            BURST:   if (w_xferLast) w_stateNxt = IDLE;
            default: w_stateNxt = IDLE;
        endcase
    end

    always_comb begin
        w_busy  = (r_state == BURST);
        w_ready = (w_busy && !ram_stall) ? r_grant : '0;
    end

    // ------------------------------------------------------------------
    // Grant lock and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant <= '0;
            r_rrPtr <= '0;
        end else if (r_state == IDLE) begin
            if (w_anyValid) begin
                r_grant <= w_arbGrant;
            end
        end else if (w_xferLast) begin
            r_grant <= '0;
            r_rrPtr <= (w_grantIdx == PTR_W'(NUM_CH - 1)) ? '0 : w_grantIdx + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Address counter and registered RAM write port. During a stall the
    // write port holds so the RAM re-samples the same write.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addrCnt  <= '0;
            r_addrWrap <= 1'b0;
            r_ramWe    <= 1'b0;
            r_ramAddr  <= '0;
            r_ramData  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_xferLast;
            if (r_state == IDLE && addr_load) begin
                r_addrCnt  <= base_addr;
                r_addrWrap <= 1'b0;
            end else if (w_xfer) begin
                r_addrCnt <= r_addrCnt + 1'b1;
                if (r_addrCnt == '1) begin
                    r_addrWrap <= 1'b1;
                end
            end
            if (!ram_stall) begin
                r_ramWe <= w_xfer;
                if (w_xfer) begin
                    r_ramAddr <= r_addrCnt;
                    r_ramData <= w_selData;
                end
            end
        end
    end

`ifdef WORD_COUNT_EN
    logic [ADDR_W-1:0] r_wordCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wordCnt <= '0;
        end else if (r_state == IDLE && w_anyValid) begin
            r_wordCnt <= '0;
        end else if (w_xfer && r_wordCnt != '1) begin
            r_wordCnt <= r_wordCnt + 1'b1;
        end
    end

    assign word_count = r_wordCnt;
`endif

    assign ch_ready  = w_ready;
    assign ram_we    = r_ramWe;
    assign ram_addr  = r_ramAddr;
    assign ram_data  = r_ramData;
    assign grant     = r_grant;
    assign busy      = w_busy;
    assign done      = r_done;
    assign addr_wrap = r_addrWrap;

endmodule
`default_nettype wire
